// File: rtl/rom_byte_fetch.sv
// rom_byte_fetch: byte reader over a registered 32-bit ROM with a one-word buffer
module rom_byte_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] byte_addr,
  input  logic        invalidate,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        rom_enable,
  output logic [29:0] rom_addr,
  input  logic [31:0] rom_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  state_t state, state_n;
  logic [31:0] buf_word;
  logic [29:0] buf_tag, lat_tag;
  logic [1:0]  lat_lane;
  logic        buf_valid, hit;
  function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] l);
    return w[{l, 3'b000} +: 8];
  endfunction
  // hit only counts in IDLE; a same-cycle invalidate forces the miss path
  always_comb begin
    hit        = state == IDLE && req && !invalidate && buf_valid && byte_addr[31:2] == buf_tag;
    state_n    = state == IDLE ? (req && !hit ? ISSUE : IDLE) : state == ISSUE ? CAPTURE : IDLE;
    busy       = state != IDLE;
    rom_enable = busy;
    rom_addr   = busy ? lat_tag : '0;
  end
  // state, word buffer, latched request and read-return registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      buf_word  <= '0;
      buf_tag   <= '0;
      buf_valid <= 1'b0;
      lat_tag   <= '0;
      lat_lane  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state    <= state_n;
      rd_valid <= 1'b0;
      if (state == IDLE) begin
        if (invalidate) buf_valid <= 1'b0;
        if (hit) begin
          rd_data  <= lane_sel(buf_word, byte_addr[1:0]);
          rd_valid <= 1'b1;
        end else if (req) begin
          lat_tag  <= byte_addr[31:2];
          lat_lane <= byte_addr[1:0];
        end
      end
      if (state == CAPTURE) begin
        buf_word  <= rom_data;
        buf_tag   <= lat_tag;
        buf_valid <= 1'b1;
        rd_data   <= lane_sel(rom_data, lat_lane);
        rd_valid  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rom_byte_fetch.sv
// tb_rom_byte_fetch: directed vector bench for rom_byte_fetch with a registered ROM model
module tb_rom_byte_fetch;
  logic        clk = 0, reset = 1, req = 0, invalidate = 0;
  logic [31:0] byte_addr = 0, rom_data = 0;
  logic [7:0]  rd_data;
  logic        rd_valid, busy, rom_enable;
  logic [29:0] rom_addr;
  int nvec = 0, nbad = 0;

  rom_byte_fetch dut (
    .clk(clk), .reset(reset), .req(req), .byte_addr(byte_addr), .invalidate(invalidate),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .rom_enable(rom_enable),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [29:0] a);
    return a == 30'h0 ? 32'h4D525341 : a == 30'h1 ? 32'h9ABCDE28 : a == 30'hF ? 32'hABCDEF00
         : {2'b00, a} ^ 32'h5A5A5A5A;
  endfunction

  always @(posedge clk) rom_data <= rom_enable ? rom_word(rom_addr) : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic inv, input logic [7:0] exp_d, input int exp_lat);
    int lat = 0, busy_n = 0;
    logic bad_rom = 0;
    @(negedge clk);
    req = 1; byte_addr = a; invalidate = inv;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (busy !== rom_enable || rom_addr !== (busy ? a[31:2] : 30'h0)) bad_rom = 1;
      if (rd_valid) break;
    end
    req = 0; invalidate = 0;
    check($sformatf("latency %h", a), lat, exp_lat);
    check($sformatf("data %h", a), rd_data, exp_d);
    check($sformatf("busy cycles %h", a), busy_n, exp_lat - 1);
    check($sformatf("rom port %h", a), bad_rom, 0);
    @(negedge clk);
    check($sformatf("pulse %h", a), rd_valid, 0);
    check($sformatf("hold %h", a), rd_data, exp_d);
  endtask

  typedef struct {
    logic [31:0] a;
    logic        inv;
    logic [7:0]  d;
    int          lat;
  } vec_t;
  vec_t v[11];

  initial begin
    v[0]  = '{32'h0,        0, 8'h41, 3};
    v[1]  = '{32'h3,        0, 8'h4D, 1};
    v[2]  = '{32'h1,        0, 8'h53, 1};
    v[3]  = '{32'h2,        0, 8'h52, 1};
    v[4]  = '{32'h3D,       0, 8'hEF, 3};
    v[5]  = '{32'h3F,       0, 8'hAB, 1};
    v[6]  = '{32'h3E,       0, 8'hCD, 1};
    v[7]  = '{32'h3C,       1, 8'h00, 3};
    v[8]  = '{32'h3C,       0, 8'h00, 1};
    v[9]  = '{32'hFFFFFFFF, 0, 8'h65, 3};
    v[10] = '{32'hFFFFFFFC, 0, 8'hA5, 1};
    repeat (2) @(negedge clk);
    reset = 0;
    check("reset rd_valid", rd_valid, 0);
    check("reset busy", busy, 0);
    check("reset rom_enable", rom_enable, 0);
    check("reset rom_addr", rom_addr, 0);
    check("reset rd_data", rd_data, 0);
    for (int i = 0; i < 11; i++) xfer(v[i].a, v[i].inv, v[i].d, v[i].lat);
    // standalone invalidate clears the buffer
    invalidate = 1;
    @(negedge clk);
    invalidate = 0;
    xfer(32'hFFFFFFFC, 0, 8'hA5, 3);
    // reset in CAPTURE aborts the fill
    req = 1; byte_addr = 32'h4;
    @(negedge clk);
    check("abort issue busy", busy, 1);
    check("abort issue rom_addr", rom_addr, 30'h1);
    @(negedge clk);
    check("abort capture busy", busy, 1);
    reset = 1;
    @(negedge clk);
    reset = 0; req = 0;
    check("abort rd_valid", rd_valid, 0);
    check("abort busy", busy, 0);
    check("abort rd_data", rd_data, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort quiet", rd_valid, 0);
    end
    xfer(32'h4, 0, 8'h28, 3);
    // back-to-back hits, one pulse per accepted request
    for (int i = 0; i < 4; i++) begin
      req = 1; byte_addr = 32'h4 + i;
      @(negedge clk);
      check($sformatf("b2b valid %0d", i), rd_valid, 1);
      check($sformatf("b2b data %0d", i), rd_data, i == 0 ? 8'h28 : i == 1 ? 8'hDE : i == 2 ? 8'hBC : 8'h9A);
      check($sformatf("b2b rom_enable %0d", i), rom_enable, 0);
    end
    req = 0;
    @(negedge clk);
    check("b2b end", rd_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/rom_byte_fetch.md
ROM_BYTE_FETCH -- requirements
Module: rom_byte_fetch

Interface
REQ-001 SHALL have no parameters; word width fixed at 32 bits, byte address 32 bits, ROM word address 30 bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req  input  1  byte read request; sampled only when busy=0.
REQ-005 SHALL have port: byte_addr  input  32  byte address of request; [31:2] word index, [1:0] byte lane.
REQ-006 SHALL have port: invalidate  input  1  clears the word buffer.
REQ-007 SHALL have port: rd_data  output  8  returned byte; valid only while rd_valid=1.
REQ-008 SHALL have port: rd_valid  output  1  one-cycle pulse marking rd_data valid.
REQ-009 SHALL have port: busy  output  1  high while a miss is in flight; new requests not accepted.
REQ-010 SHALL have port: rom_enable  output  1  drives ROM enable; ROM data is zero when low.
REQ-011 SHALL have port: rom_addr  output  30  word address to ROM.
REQ-012 SHALL have port: rom_data  input  32  ROM read data; registered in ROM, valid one cycle after rom_addr is sampled, gated by rom_enable.

Function
REQ-013 SHALL hold a one-word buffer: buf_word[31:0], buf_tag[29:0], buf_valid.
REQ-014 SHALL implement states IDLE, ISSUE, CAPTURE; reset state IDLE.
REQ-015 IDLE: req=1 with buf_valid=1 and byte_addr[31:2]=buf_tag (hit) SHALL set rd_data to selected lane and rd_valid=1 on the next cycle; remain IDLE.
REQ-016 IDLE: req=1 on miss SHALL latch byte_addr and go to ISSUE; busy=1 from the next cycle.
REQ-017 ISSUE: rom_addr = latched [31:2], rom_enable=1; go to CAPTURE unconditionally.
REQ-018 CAPTURE: rom_addr held, rom_enable=1; SHALL load buf_word<=rom_data, buf_tag<=latched [31:2], buf_valid<=1, rd_data<=selected lane, rd_valid<=1 next cycle; go to IDLE.
REQ-019 Latency req-accept to rd_valid: hit 1 cycle, miss 3 cycles.
REQ-020 Lane selection SHALL be little-endian: lane 0 -> bits [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
REQ-021 busy SHALL be 1 exactly in ISSUE and CAPTURE; req while busy=1 SHALL be ignored (requester holds req).
REQ-022 rom_enable SHALL be 0 in IDLE; rom_addr SHALL be 0 in IDLE.
REQ-023 rd_valid SHALL be a single-cycle pulse; rd_data SHALL hold its last value when rd_valid=0.
REQ-024 invalidate in IDLE SHALL clear buf_valid next cycle; invalidate with req same cycle SHALL treat req as miss.
REQ-025 invalidate during ISSUE or CAPTURE SHALL be ignored; the in-flight fill completes and sets buf_valid=1.
REQ-026 Back-to-back hits SHALL be accepted every cycle, one rd_valid per accepted req.
REQ-027 byte_addr[31:2] wider than ROM space SHALL be truncated to 30 bits with no error.

Reset
REQ-028 reset=1 SHALL, on the next edge: state IDLE, buf_valid=0, buf_tag=0, buf_word=0, rd_data=0, rd_valid=0; busy, rom_enable, rom_addr 0.
REQ-029 reset during ISSUE or CAPTURE SHALL abort the fill with no rd_valid and no buffer update; reset overrides req and invalidate.

Verification
REQ-030 ROM word 0 = 0x4D525341: reset, req byte_addr=0 -> busy 2 cycles, rd_valid 3 cycles after accept, rd_data=0x41.
REQ-031 Then req byte_addr=3 -> hit, rd_valid next cycle, rd_data=0x4D, rom_enable stays 0.
REQ-032 ROM word 0xF = 0xABCDEF00: req byte_addr=0x3D -> miss, rd_data=0xEF; then 0x3F -> hit 0xAB.
REQ-033 invalidate+req byte_addr=0x3C same cycle with buffer holding tag 0xF -> miss path, rd_data=0x00, rom_addr=0xF in ISSUE/CAPTURE.
REQ-034 reset asserted in CAPTURE of miss to byte_addr=4 -> no rd_valid; following req byte_addr=4 -> miss, rd_data=0x28.
REQ-035 req held high while busy -> exactly one rd_valid for that request; subsequent hits one pulse per cycle.
